video_timing_sink: RTL and testbench
====================================

VIDEO_TIMING_SINK -- requirements
Module: video_timing_sink

Interface
REQ-001 The block SHALL have parameter IMG_DATA_WIDTH, default 8, the pixel width of the input stream.
REQ-002 The block SHALL have parameters H_ACTIVE 800, H_FP 40, H_SYNC 128, H_BP 88 (horizontal timing, pixels).
REQ-003 The block SHALL have parameters V_ACTIVE 600, V_FP 1, V_SYNC 4, V_BP 23 (vertical timing, lines).
REQ-004 The block SHALL have the port pixel_clk, input, 1 bit: the single clock; all logic rises on it.
REQ-005 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have the port pixel_stream_data, input, IMG_DATA_WIDTH bits: the incoming pixel.
REQ-007 The block SHALL have the port pixel_stream_valid, input, 1 bit: the source holds a valid pixel.
REQ-008 The block SHALL have the port pixel_stream_ready, output, 1 bit: the sink accepts a pixel this cycle.
REQ-009 The block SHALL have the port video_out_pixel, output, 24 bits: the RGB output ({R,G,B}, 8 bits each).
REQ-010 The block SHALL have the port video_out_de, output, 1 bit: the data-enable (active region).
REQ-011 The block SHALL have the port video_out_hsync, output, 1 bit: horizontal sync, active high.
REQ-012 The block SHALL have the port video_out_vsync, output, 1 bit: vertical sync, active high.
REQ-013 The block SHALL have the port underflow_count, output, 16 bits: the count of underflowed pixels.

Function
REQ-014 The block SHALL keep h_cnt in 0..H_TOTAL-1 and v_cnt in 0..V_TOTAL-1, where H_TOTAL = sum of the H_* parameters (1056) and V_TOTAL = sum of the V_* parameters (628).
REQ-015 h_cnt SHALL increment every cycle; at H_TOTAL-1 it SHALL wrap to 0 and v_cnt SHALL increment.
REQ-016 v_cnt SHALL wrap to 0 when both counters are at their maxima, which starts the next frame.
REQ-017 active SHALL equal (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
REQ-018 pixel_stream_ready SHALL equal active && !rst, combinational from the registered counters, with no dependence on valid.
REQ-019 fire SHALL equal pixel_stream_valid && pixel_stream_ready; exactly one pixel SHALL be consumed per fire.
REQ-020 The output registers SHALL update one cycle after the counter state, giving 1-cycle latency from a fire to video_out_pixel.
REQ-021 On a fire, video_out_pixel SHALL become {data[7:0], data[7:0], data[7:0]} (grayscale); when IMG_DATA_WIDTH > 8, the MSBs SHALL be used; when IMG_DATA_WIDTH < 8, the data SHALL be left-aligned and zero-padded.
REQ-022 When active && !valid (an underflow), video_out_pixel SHALL be 24'h000000 and video_out_de SHALL still be 1; that pixel slot is dropped, not deferred.
REQ-023 Outside the active region, video_out_pixel SHALL be 0 and video_out_de SHALL be 0.
REQ-024 video_out_hsync SHALL be 1 for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (h_cnt 840..967).
REQ-025 video_out_vsync SHALL be 1 for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (v_cnt 601..604), for the whole line.
REQ-026 All three timing outputs SHALL be registered and aligned in the same cycle as video_out_pixel.
REQ-027 A valid asserted outside the active region SHALL be ignored, SHALL NOT be consumed, and SHALL NOT be counted.

Reset
REQ-028 While rst=1, h_cnt, v_cnt, video_out_pixel, video_out_de, video_out_hsync, video_out_vsync and underflow_count SHALL all be 0, asynchronously.
REQ-029 While rst=1, pixel_stream_ready SHALL be 0, so no fire occurs during reset.
REQ-030 After rst deasserts, the first edge SHALL see h_cnt=v_cnt=0 and ready=1, and the first fire SHALL be pixel (0,0).
REQ-031 A reset mid-frame SHALL abort the frame; the source is expected to be reset alongside.

Configuration
REQ-032 With macro VIDEO_SINK_UNDERFLOW_CNT_EN defined, underflow_count SHALL increment by 1 on each underflow cycle (REQ-022).
REQ-033 With the macro defined, underflow_count SHALL saturate at 16'hFFFF and SHALL clear only on rst.
REQ-034 Without the macro, underflow_count SHALL be tied to 0 and no counter logic SHALL be built.

Verification
REQ-035 Reset, then valid=1 constant and data=8'h5A: ready=1 at h_cnt 0..799; video_out_pixel=24'h5A5A5A with de=1 one cycle later; 800 fires per line.
REQ-036 Free-run, one line: hsync=1 for exactly 128 cycles, rising 841 cycles after line start; line period 1056 cycles.
REQ-037 Free-run, one frame: vsync=1 for exactly 4*1056 cycles; frame period 1056*628 = 663168 cycles; 480000 fires per frame.
REQ-038 Drop valid for 10 active cycles: those outputs are 24'h000000 with de=1; underflow_count=10 with the macro, 0 without.
REQ-039 Assert rst at h_cnt=400, v_cnt=300: all outputs 0 and ready=0 immediately; after release the counters restart at 0,0.
REQ-040 Hold valid=1 during blanking (h_cnt=900): ready=0, no fire, and the data is held until the next active pixel.

Source files
------------

// File: rtl/video_timing_sink.sv
// Grayscale pixel-stream sink that paces a source with a raster timing generator and emits RGB video with DE/HSYNC/VSYNC.
// Define VIDEO_SINK_UNDERFLOW_CNT_EN to build the saturating underflow counter; otherwise underflow_count reads 0.
module video_timing_sink #(
    parameter int IMG_DATA_WIDTH = 8,
    parameter int H_ACTIVE       = 800,
    parameter int H_FP           = 40,
    parameter int H_SYNC         = 128,
    parameter int H_BP           = 88,
    parameter int V_ACTIVE       = 600,
    parameter int V_FP           = 1,
    parameter int V_SYNC         = 4,
    parameter int V_BP           = 23
) (
    input  logic                      pixel_clk,
    input  logic                      rst,
    input  logic [IMG_DATA_WIDTH-1:0] pixel_stream_data,
    input  logic                      pixel_stream_valid,
    output logic                      pixel_stream_ready,
    output logic [23:0]               video_out_pixel,
    output logic                      video_out_de,
    output logic                      video_out_hsync,
    output logic                      video_out_vsync,
    output logic [15:0]               underflow_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_MAX    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_MAX    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [23:0]   pixel_q, pixel_d;
    logic          de_q, de_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          active;
    logic          fire;
    logic [7:0]    gray;

    // Reduce the input to one byte: keep the MSBs of wide pixels, left-align narrow ones.
    generate
        if (IMG_DATA_WIDTH >= 8) begin : g_gray_msb
            assign gray = pixel_stream_data[IMG_DATA_WIDTH-1 -: 8];
        end else begin : g_gray_pad
            assign gray = {pixel_stream_data, {(8 - IMG_DATA_WIDTH){1'b0}}};
        end
    endgenerate

    assign active             = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign pixel_stream_ready = active && !rst;
    assign fire               = pixel_stream_valid && pixel_stream_ready;

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_MAX) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + 1'b1;
        end
        // An underflowed slot shows black with DE still high; the missing pixel is not deferred.
        pixel_d = fire ? {gray, gray, gray} : 24'h000000;
        de_d    = active;
        hsync_d = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        vsync_d = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            pixel_q <= 24'h000000;
            de_q    <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            pixel_q <= pixel_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign video_out_pixel = pixel_q;
    assign video_out_de    = de_q;
    assign video_out_hsync = hsync_q;
    assign video_out_vsync = vsync_q;

`ifdef VIDEO_SINK_UNDERFLOW_CNT_EN
    logic [15:0] uf_cnt_q, uf_cnt_d;

    always_comb begin
        uf_cnt_d = uf_cnt_q;
        if (active && !pixel_stream_valid && (uf_cnt_q != 16'hFFFF)) begin
            uf_cnt_d = uf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            uf_cnt_q <= 16'h0000;
        end else begin
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign underflow_count = uf_cnt_q;
`else
    assign underflow_count = 16'h0000;
`endif

endmodule

// File: tb/tb_video_timing_sink.sv
// Bench for video_timing_sink on a shrunken raster (32x12 total, 16x6 active) so whole frames fit in a short run.
// Handshake: a pixel moves on a rising edge where pixel_stream_valid && pixel_stream_ready; ready never depends on valid.
module tb_video_timing_sink;

  localparam int H_A = 16, H_F = 4, H_S = 8, H_B = 4;
  localparam int V_A = 6, V_F = 1, V_S = 2, V_B = 3;
  localparam int H_T = H_A + H_F + H_S + H_B;
  localparam int V_T = V_A + V_F + V_S + V_B;
  localparam int W = 43;

  logic        clk;
  logic        rst;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic [23:0] pix;
  logic        de, hs, vs;
  logic [15:0] uf;

  video_timing_sink #(
    .IMG_DATA_WIDTH(8),
    .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
    .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B)
  ) dut (
    .pixel_clk(clk),
    .rst(rst),
    .pixel_stream_data(data),
    .pixel_stream_valid(valid),
    .pixel_stream_ready(ready),
    .video_out_pixel(pix),
    .video_out_de(de),
    .video_out_hsync(hs),
    .video_out_vsync(vs),
    .underflow_count(uf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int fire_cnt = 0;
  int m_h = 0;
  int m_v = 0;
  logic [15:0] m_uf = 16'h0000;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic [23:0] exp_pix;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s h=%0d v=%0d got=%h exp=%h", name, m_h, m_v, got, exp);
    end
  endtask

  // driver + scoreboard: push the expected output when driving, pop it one edge later
  task automatic step(input logic v, input logic [7:0] d, input logic use_tab, input logic [23:0] tab_pix);
    logic act, e_hs, e_vs;
    logic [23:0] ep;
    logic [W-1:0] got_w;
    @(negedge clk);
    valid = v;
    data = d;
    #1;
    act = (m_h < H_A) && (m_v < V_A);
    check("ready", W'(ready), W'(act));
    if (act && v) fire_cnt++;
    ep = (act && v) ? {d, d, d} : 24'h000000;
    if (use_tab) ep = tab_pix;
`ifdef VIDEO_SINK_UNDERFLOW_CNT_EN
    if (act && !v && m_uf != 16'hFFFF) m_uf = m_uf + 16'd1;
`endif
    e_hs = (m_h >= H_A + H_F) && (m_h < H_A + H_F + H_S);
    e_vs = (m_v >= V_A + V_F) && (m_v < V_A + V_F + V_S);
    exp_q.push_back({ep, act, e_hs, e_vs, m_uf});
    @(posedge clk);
    #1;
    got_w = {pix, de, hs, vs, uf};
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_empty h=%0d v=%0d", m_h, m_v);
    end else begin
      check("outputs", got_w, exp_q.pop_front());
    end
    m_h++;
    if (m_h == H_T) begin
      m_h = 0;
      m_v++;
      if (m_v == V_T) m_v = 0;
    end
  endtask

  task automatic check_reset_state(input string name);
    check(name, {pix, de, hs, vs, uf}, '0);
    check({name, "_ready"}, W'(ready), '0);
  endtask

  initial begin
    int first_hs, line_hs, frame_hs, frame_vs, frame_de, guard, fires_blank;
    logic [15:0] uf_before;
    logic [7:0] r;

    vecs[0]  = '{1'b1, 8'h5A, 24'h5A5A5A};
    vecs[1]  = '{1'b1, 8'hFF, 24'hFFFFFF};
    vecs[2]  = '{1'b1, 8'h00, 24'h000000};
    vecs[3]  = '{1'b1, 8'h01, 24'h010101};
    vecs[4]  = '{1'b1, 8'h80, 24'h808080};
    vecs[5]  = '{1'b0, 8'h77, 24'h000000};
    vecs[6]  = '{1'b1, 8'hA5, 24'hA5A5A5};
    vecs[7]  = '{1'b1, 8'h3C, 24'h3C3C3C};
    vecs[8]  = '{1'b0, 8'h12, 24'h000000};
    vecs[9]  = '{1'b1, 8'hC3, 24'hC3C3C3};
    vecs[10] = '{1'b1, 8'h7E, 24'h7E7E7E};
    vecs[11] = '{1'b1, 8'hE7, 24'hE7E7E7};
    vecs[12] = '{1'b0, 8'hAA, 24'h000000};
    vecs[13] = '{1'b1, 8'h10, 24'h101010};
    vecs[14] = '{1'b1, 8'h20, 24'h202020};
    vecs[15] = '{1'b1, 8'hF0, 24'hF0F0F0};

    rst = 1'b1;
    valid = 1'b1;
    data = 8'h99;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_state("reset_init");
    @(posedge clk);
    #2;
    rst = 1'b0;

    // first active line from the table; first accepted pixel is (0,0)
    for (int i = 0; i < 16; i++) step(vecs[i].valid, vecs[i].data, 1'b1, vecs[i].exp_pix);

    guard = 0;
    while (!(m_h == 0 && m_v == 0) && guard < 1000) begin
      r = 8'($urandom_range(0, 255));
      step(1'b1, r, 1'b0, 24'h0);
      guard++;
    end
    check("frame_align_timeout", W'(m_h + m_v), '0);

    // one whole frame, free-running with valid held high
    first_hs = -1; line_hs = 0; frame_hs = 0; frame_vs = 0; frame_de = 0; fire_cnt = 0;
    for (int i = 0; i < H_T * V_T; i++) begin
      r = 8'($urandom_range(0, 255));
      step(1'b1, r, 1'b0, 24'h0);
      if (i < H_T && hs) begin
        line_hs++;
        if (first_hs < 0) first_hs = i;
      end
      frame_hs += int'(hs);
      frame_vs += int'(vs);
      frame_de += int'(de);
    end
    check("hsync_first", W'(first_hs), W'(H_A + H_F));
    check("hsync_line_len", W'(line_hs), W'(H_S));
    check("hsync_frame", W'(frame_hs), W'(H_S * V_T));
    check("vsync_frame", W'(frame_vs), W'(V_S * H_T));
    check("de_frame", W'(frame_de), W'(H_A * V_A));
    check("fires_frame", W'(fire_cnt), W'(H_A * V_A));

    // underflow: 10 active slots without valid
    uf_before = uf;
    for (int i = 0; i < 10; i++) step(1'b0, 8'h55, 1'b0, 24'h0);
`ifdef VIDEO_SINK_UNDERFLOW_CNT_EN
    check("underflow_delta", W'(uf - uf_before), W'(10));
`else
    check("underflow_delta", W'(uf - uf_before), W'(0));
`endif
    for (int i = 0; i < 6; i++) step(1'b1, 8'h44, 1'b0, 24'h0);

    // valid held through blanking: no fire until the next active pixel takes it
    fire_cnt = 0;
    guard = 0;
    while (m_h != 0 && guard < 2 * H_T) begin
      step(1'b1, 8'hC3, 1'b0, 24'h0);
      guard++;
    end
    fires_blank = fire_cnt;
    check("blank_fires", W'(fires_blank), '0);
    step(1'b1, 8'hC3, 1'b0, 24'h0);
    check("held_pixel", W'(pix), W'(24'hC3C3C3));

    // mid-frame reset inside the active area
    guard = 0;
    while (!(m_h == 8 && m_v == 5) && guard < H_T * V_T) begin
      r = 8'($urandom_range(0, 255));
      step(1'b1, r, 1'b0, 24'h0);
      guard++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_state("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset_hold");
    @(posedge clk);
    #2;
    rst = 1'b0;
    m_h = 0;
    m_v = 0;
    m_uf = 16'h0000;
    step(1'b1, 8'h3A, 1'b0, 24'h0);
    check("restart_pixel00", W'({pix, de}), W'({24'h3A3A3A, 1'b1}));
    for (int i = 0; i < 40; i++) begin
      r = 8'($urandom_range(0, 255));
      step(r[0] | r[1], r, 1'b0, 24'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
